// File: rtl/cpc2_reset_pkg.sv
// rtl/cpc2_reset_pkg.sv - shared FSM state and reset-cause encodings for the reset request front end
package cpc2_reset_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_BUTTON = 2'b01,
    CAUSE_WDT    = 2'b10,
    CAUSE_SW     = 2'b11
  } cause_t;

  // Button outranks watchdog, watchdog outranks software when several fire together.
  function automatic cause_t select_cause(input logic button, input logic wdt, input logic sw);
    if (button)   return CAUSE_BUTTON;
    else if (wdt) return CAUSE_WDT;
    else if (sw)  return CAUSE_SW;
    else          return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/reset_request_if.sv
// rtl/reset_request_if.sv - reset source inputs and reset request outputs of reset_request
interface reset_request_if;

  logic       button_n_i;
  logic       sw_reset_i;
  logic       wdt_enable_i;
  logic       wdt_kick_i;
  logic       forced_reset_o;
  logic [1:0] cause_o;

  modport master (
    output button_n_i, sw_reset_i, wdt_enable_i, wdt_kick_i,
    input  forced_reset_o, cause_o
  );

  modport slave (
    input  button_n_i, sw_reset_i, wdt_enable_i, wdt_kick_i,
    output forced_reset_o, cause_o
  );

endinterface

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchronizer and stable-count debouncer for the active-low reset button
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock_i,
  input  logic n_reset_i,
  input  logic button_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      sync_q  <= 2'b11;
      level_o <= 1'b1;
      cnt_q   <= '0;
      press_o <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], button_n_i};
      press_o <= 1'b0;
      if (sync_q[1] == level_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_o <= sync_q[1];
        cnt_q   <= '0;
        // Only the 1->0 flip (button pressed) is a press event.
        press_o <= level_o;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_request.sv
// rtl/reset_request.sv - merges button, watchdog and software resets into a minimum-width forced reset pulse
module reset_request
  import cpc2_reset_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          PULSE_CYCLES    = 255,
  parameter logic [23:0] WDT_LIMIT       = 24'd8000000
) (
  input logic             clock_i,
  input logic             n_reset_i,
  reset_request_if.slave  bus
);

  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES - 1);
  localparam logic [23:0] WDT_LAST   = WDT_LIMIT - 24'd1;

  logic        btn_level;
  logic        btn_press;
  logic [23:0] wdt_cnt_q;
  logic        wdt_fire;
  logic [15:0] pulse_cnt_q;
  state_t      state_q;
  logic        any_trigger;

  button_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_button_debounce (
    .clock_i    (clock_i),
    .n_reset_i  (n_reset_i),
    .button_n_i (bus.button_n_i),
    .level_o    (btn_level),
    .press_o    (btn_press)
  );

  // A kick in the same cycle as the limit suppresses the fire.
  assign wdt_fire = bus.wdt_enable_i && !bus.wdt_kick_i && (state_q == ST_IDLE)
                    && (wdt_cnt_q == WDT_LAST);

  assign any_trigger = btn_press || wdt_fire || bus.sw_reset_i;

  always_ff @(posedge clock_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      wdt_cnt_q <= '0;
    end else if (!bus.wdt_enable_i || bus.wdt_kick_i || (state_q != ST_IDLE) || wdt_fire) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clock_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state_q            <= ST_IDLE;
      pulse_cnt_q        <= '0;
      bus.forced_reset_o <= 1'b0;
      bus.cause_o        <= CAUSE_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (any_trigger) begin
            state_q            <= ST_ASSERT;
            pulse_cnt_q        <= PULSE_LOAD;
            bus.forced_reset_o <= 1'b1;
            bus.cause_o        <= select_cause(btn_press, wdt_fire, bus.sw_reset_i);
          end
        end
        ST_ASSERT: begin
          if (pulse_cnt_q == 16'd0) begin
            // Stretch the pulse while the debounced button is still held.
            if (!btn_level) begin
              state_q <= ST_HOLDOFF;
            end else begin
              state_q            <= ST_IDLE;
              bus.forced_reset_o <= 1'b0;
            end
          end else begin
            pulse_cnt_q <= pulse_cnt_q - 16'd1;
          end
        end
        ST_HOLDOFF: begin
          if (btn_level) begin
            state_q            <= ST_IDLE;
            bus.forced_reset_o <= 1'b0;
          end
        end
        default: begin
          state_q            <= ST_IDLE;
          bus.forced_reset_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_request.sv
// tb/tb_reset_request.sv - scoreboard bench for reset_request pulse timing, width and cause
module tb_reset_request;

  typedef struct {
    int         rise;
    int         fall;
    logic [1:0] cause;
  } exp_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  reset_request_if bus();

  reset_request #(
    .DEBOUNCE_CYCLES (4),
    .PULSE_CYCLES    (8),
    .WDT_LIMIT       (24'd20)
  ) dut (
    .clock_i   (clk),
    .n_reset_i (n_reset),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pulse monitor: each rise/fall of forced_reset_o is matched against the scoreboard head.
  logic prev_forced = 1'b0;
  always @(negedge clk) begin
    if (!prev_forced && bus.forced_reset_o) begin
      if (sb.size() == 0) begin
        check("spurious_rise", 32'd1, 32'd0);
      end else begin
        check("rise_cycle", 32'(cyc), 32'(sb[0].rise));
        check("cause_at_rise", 32'(bus.cause_o), 32'(sb[0].cause));
      end
    end else if (prev_forced && !bus.forced_reset_o && sb.size() != 0) begin
      check("fall_cycle", 32'(cyc), 32'(sb[0].fall));
      void'(sb.pop_front());
    end
    prev_forced = bus.forced_reset_o;
  end

  initial begin
    int n, k, kick_cyc, m;
    bus.button_n_i   = 1'b1;
    bus.sw_reset_i   = 1'b0;
    bus.wdt_enable_i = 1'b0;
    bus.wdt_kick_i   = 1'b0;

    step(3);
    check("reset_forced", 32'(bus.forced_reset_o), 32'd0);
    check("reset_cause", 32'(bus.cause_o), 32'd0);
    n_reset = 1'b1;
    step(100);
    check("idle_forced", 32'(bus.forced_reset_o), 32'd0);
    check("idle_cause", 32'(bus.cause_o), 32'd0);

    // Software strobe, plus a second strobe mid-pulse that must be dropped.
    step();
    n = cyc;
    sb.push_back('{rise: n + 1, fall: n + 9, cause: 2'b11});
    bus.sw_reset_i = 1'b1;
    step();
    bus.sw_reset_i = 1'b0;
    step(3);
    bus.sw_reset_i = 1'b1;
    step();
    bus.sw_reset_i = 1'b0;
    step(15);

    // Bouncing button never settles long enough.
    for (int i = 0; i < 10; i++) begin
      bus.button_n_i = i[0];
      step(2);
    end
    bus.button_n_i = 1'b1;
    step(20);

    // Held button: pulse stretched until debounced release plus one edge.
    k = cyc;
    sb.push_back('{rise: k + 7, fall: k + 57, cause: 2'b01});
    bus.button_n_i = 1'b0;
    step(50);
    bus.button_n_i = 1'b1;
    step(20);

    // Watchdog serviced every 15 cycles, then left to expire.
    bus.wdt_enable_i = 1'b1;
    kick_cyc = cyc;
    for (int i = 0; i < 14; i++) begin
      kick_cyc = cyc;
      bus.wdt_kick_i = 1'b1;
      step();
      bus.wdt_kick_i = 1'b0;
      step(14);
    end
    sb.push_back('{rise: kick_cyc + 21, fall: kick_cyc + 29, cause: 2'b10});
    step(7);
    bus.wdt_enable_i = 1'b0;
    step(20);

    // Button press, watchdog fire and software strobe all in one cycle.
    step();
    m = cyc;
    bus.wdt_enable_i = 1'b1;
    step(13);
    k = cyc;
    sb.push_back('{rise: k + 7, fall: k + 37, cause: 2'b01});
    bus.button_n_i = 1'b0;
    step(6);
    check("prio_alignment", 32'(cyc - m), 32'd19);
    bus.sw_reset_i = 1'b1;
    step();
    bus.sw_reset_i = 1'b0;
    bus.wdt_enable_i = 1'b0;
    step(23);
    bus.button_n_i = 1'b1;
    step(20);

    // Reset asserted during ASSERT drops the request immediately.
    step();
    n = cyc;
    sb.push_back('{rise: n + 1, fall: n + 3, cause: 2'b11});
    bus.sw_reset_i = 1'b1;
    step();
    bus.sw_reset_i = 1'b0;
    step(2);
    n_reset = 1'b0;
    #1;
    check("async_forced", 32'(bus.forced_reset_o), 32'd0);
    check("async_cause", 32'(bus.cause_o), 32'd0);
    step(2);
    n_reset = 1'b1;
    step(30);
    check("post_reset_forced", 32'(bus.forced_reset_o), 32'd0);
    check("post_reset_cause", 32'(bus.cause_o), 32'd0);

    check("pending_pulses", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
